// File: rtl/mem_arb_pkg.sv
// Shared definitions for the instruction/data memory request arbiter:
// requester IDs carried in the order FIFO, FSM encoding and size codes.
package mem_arb_pkg;

  localparam logic REQ_INST = 1'b0;
  localparam logic REQ_DATA = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD_I = 2'd1,
    HOLD_D = 2'd2
  } arb_state_t;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/ost_id_fifo.sv
// Order FIFO of 1-bit requester IDs for in-flight memory transactions.
// The head names the requester owning the next downstream response.
module ost_id_fifo #(
  parameter int DEPTH = 2,
  parameter int PTR_W = $clog2(DEPTH),
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic             din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic             head,
  output logic [CNT_W-1:0] count
);

  logic [DEPTH-1:0] id_mem;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign head  = id_mem[rd_ptr];

  // Pop on empty is dropped; a push into a full FIFO is only legal alongside a pop.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Storage, pointers (wrap naturally at power-of-two depth) and occupancy.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      id_mem <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        id_mem[wr_ptr] <= din;
        wr_ptr         <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// Arbitrates instruction fetch and data memory requesters onto one shared
// sram-like port and routes responses back in issue order.
// Optional build macro: MEM_ARB_RR_EN selects round-robin on conflicts;
// without it data has fixed priority over inst.
//
//   state  | meaning
//   IDLE   | no request pending downstream; combinational arbitration
//   HOLD_I | inst request issued, waiting for mem_addr_ok (grant locked)
//   HOLD_D | data request issued, waiting for mem_addr_ok (grant locked)
module mem_req_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int OST_DEPTH = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic [1:0]        inst_size,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [ADDR_W-1:0] inst_rdata,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [3:0]        data_wstrb,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [ADDR_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [ADDR_W-1:0] data_rdata,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [1:0]        mem_size,
  output logic [3:0]        mem_wstrb,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [ADDR_W-1:0] mem_wdata,
  input  logic              mem_addr_ok,
  input  logic              mem_data_ok,
  input  logic [ADDR_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(OST_DEPTH) + 1;

  arb_state_t       state;
  arb_state_t       state_nxt;
  logic             grant_vld;
  logic             grant_id;
  logic             conflict_winner;
  logic             accept;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_head;
  logic [CNT_W-1:0] fifo_count;
  logic             lock_room;

`ifdef MEM_ARB_RR_EN
  logic last_grant;

  // Remember who was accepted last so the other side wins the next conflict.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_grant <= REQ_INST;
    end else if (accept) begin
      last_grant <= grant_id;
    end
  end

  assign conflict_winner = ~last_grant;
`else
  assign conflict_winner = REQ_DATA;
`endif

  // Locking only makes sense while an ID slot is still free for the eventual accept.
  assign lock_room = (fifo_count < CNT_W'(OST_DEPTH));

  // FSM state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Grant selection and next state; grant is forced off while reset is asserted.
  always_comb begin
    state_nxt = state;
    grant_vld = 1'b0;
    grant_id  = REQ_INST;
    case (state)
      IDLE: begin
        if (!fifo_full) begin
          if (inst_req && data_req) begin
            grant_vld = 1'b1;
            grant_id  = conflict_winner;
          end else if (data_req) begin
            grant_vld = 1'b1;
            grant_id  = REQ_DATA;
          end else if (inst_req) begin
            grant_vld = 1'b1;
            grant_id  = REQ_INST;
          end
          if (grant_vld && !mem_addr_ok && lock_room) begin
            state_nxt = (grant_id == REQ_DATA) ? HOLD_D : HOLD_I;
          end
        end
      end
      HOLD_I: begin
        grant_vld = 1'b1;
        grant_id  = REQ_INST;
        if (mem_addr_ok) state_nxt = IDLE;
      end
      HOLD_D: begin
        grant_vld = 1'b1;
        grant_id  = REQ_DATA;
        if (mem_addr_ok) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (!resetn) grant_vld = 1'b0;
  end

  // Downstream request mux; every field is zero when nothing is granted.
  always_comb begin
    mem_req   = grant_vld;
    mem_wr    = 1'b0;
    mem_size  = 2'd0;
    mem_wstrb = 4'd0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (grant_vld) begin
      if (grant_id == REQ_DATA) begin
        mem_wr    = data_wr;
        mem_size  = data_size;
        mem_wstrb = data_wstrb;
        mem_addr  = data_addr;
        mem_wdata = data_wdata;
      end else begin
        mem_size  = inst_size;
        mem_addr  = inst_addr;
      end
    end
  end

  assign accept       = grant_vld & mem_addr_ok;
  assign inst_addr_ok = accept & (grant_id == REQ_INST);
  assign data_addr_ok = accept & (grant_id == REQ_DATA);

  // A response with nothing outstanding is a protocol error and is dropped.
  assign pop          = mem_data_ok & ~fifo_empty & resetn;
  assign inst_data_ok = pop & (fifo_head == REQ_INST);
  assign data_data_ok = pop & (fifo_head == REQ_DATA);
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;

  ost_id_fifo #(
    .DEPTH (OST_DEPTH)
  ) u_ost_id_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (accept),
    .din    (grant_id),
    .pop    (pop),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .head   (fifo_head),
    .count  (fifo_count)
  );

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Self-checking bench for mem_req_arbiter: directed scenarios followed by
// random traffic, all compared against a transaction-level reference model
// (ID queue, pending grant, last-granted requester).
module tb_mem_req_arbiter;

  localparam int DEPTH = 2;

  logic        clk;
  logic        resetn;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic [1:0]  inst_size;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_req;
  logic        mem_wr;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_addr_ok;
  logic        mem_data_ok;
  logic [31:0] mem_rdata;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  int q[$];
  int pend_id   = -1;
  int last_id   = 0;
  bit inst_hold = 0;
  bit data_hold = 0;

  mem_req_arbiter #(.ADDR_W(32), .OST_DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_size(inst_size),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    inst_req = 0; inst_addr = 0; inst_size = 0;
    data_req = 0; data_wr = 0; data_size = 0; data_wstrb = 0; data_addr = 0; data_wdata = 0;
    mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
  endtask

  task automatic model_reset();
    q.delete();
    pend_id = -1; last_id = 0; inst_hold = 0; data_hold = 0;
  endtask

  // Compare current outputs with the model, then advance the model by one cycle.
  task automatic evaluate();
    int cnt;
    bit v;
    int g;
    bit acc;
    bit pop;
    int head;
    #3;
    cnt = q.size(); v = 0; g = 0; head = -1;
    if (cnt > 0) head = q[0];
    if (pend_id >= 0) begin
      v = 1; g = pend_id;
    end else if (cnt < DEPTH) begin
      if (inst_req && data_req) begin
        v = 1;
`ifdef MEM_ARB_RR_EN
        g = (last_id == 0) ? 1 : 0;
`else
        g = 1;
`endif
      end else if (data_req) begin
        v = 1; g = 1;
      end else if (inst_req) begin
        v = 1; g = 0;
      end
    end
    acc = v && mem_addr_ok;
    pop = mem_data_ok && (cnt > 0);

    chk("mem_req",   32'(mem_req), 32'(v));
    chk("mem_addr",  mem_addr,  !v ? 32'd0 : (g == 1 ? data_addr : inst_addr));
    chk("mem_wr",    32'(mem_wr),    (v && g == 1) ? 32'(data_wr) : 32'd0);
    chk("mem_size",  32'(mem_size),  !v ? 32'd0 : (g == 1 ? 32'(data_size) : 32'(inst_size)));
    chk("mem_wstrb", 32'(mem_wstrb), (v && g == 1) ? 32'(data_wstrb) : 32'd0);
    chk("mem_wdata", mem_wdata,      (v && g == 1) ? data_wdata : 32'd0);
    chk("inst_addr_ok", 32'(inst_addr_ok), 32'(acc && g == 0));
    chk("data_addr_ok", 32'(data_addr_ok), 32'(acc && g == 1));
    chk("inst_data_ok", 32'(inst_data_ok), 32'(pop && head == 0));
    chk("data_data_ok", 32'(data_data_ok), 32'(pop && head == 1));
    chk("inst_rdata", inst_rdata, mem_rdata);
    chk("data_rdata", data_rdata, mem_rdata);

    if (pop) void'(q.pop_front());
    if (acc) begin
      q.push_back(g);
      last_id = g;
    end
    pend_id = (v && !acc) ? g : -1;
    if (acc && g == 0) inst_hold = 0; else if (inst_req) inst_hold = 1;
    if (acc && g == 1) data_hold = 0; else if (data_req) data_hold = 1;
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    evaluate();
    advance();
  endtask

  task automatic drain();
    inst_req = 0; data_req = 0; mem_addr_ok = 0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      mem_data_ok = (q.size() > 0);
      mem_rdata   = $urandom;
      step();
    end
    mem_data_ok = 0;
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_mem_req"},   32'(mem_req), 0);
    chk({tag, "_mem_addr"},  mem_addr, 0);
    chk({tag, "_mem_fields"}, 32'({mem_wr, mem_size, mem_wstrb}), 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_addr_ok"},   32'({inst_addr_ok, data_addr_ok}), 0);
    chk({tag, "_data_ok"},   32'({inst_data_ok, data_data_ok}), 0);
  endtask

  task automatic gen_random();
    if (!inst_hold) begin
      inst_req  = ($urandom_range(0, 2) != 0);
      inst_addr = $urandom & 32'hFFFF_FFFC;
      inst_size = 2'($urandom_range(0, 2));
    end
    if (!data_hold) begin
      data_req   = ($urandom_range(0, 2) != 0);
      data_wr    = 1'($urandom_range(0, 1));
      data_size  = 2'($urandom_range(0, 2));
      data_wstrb = 4'($urandom_range(0, 15));
      data_addr  = $urandom;
      data_wdata = $urandom;
    end
    mem_addr_ok = ($urandom_range(0, 1) != 0);
    mem_data_ok = (q.size() > 0) ? ($urandom_range(0, 1) != 0) : ($urandom_range(0, 19) == 0);
    mem_rdata   = $urandom;
  endtask

  initial begin
    clear_inputs();
    model_reset();
    resetn = 0;
    #2;
    check_outputs_zero("reset");
    @(posedge clk); #1;
    resetn = 1;

    // inst only: accept in cycle 0, response in cycle 2
    inst_req = 1; inst_addr = 32'h1C00_0000; inst_size = 2'd2; mem_addr_ok = 1;
    step();
    inst_req = 0; mem_addr_ok = 0;
    step();
    mem_data_ok = 1; mem_rdata = 32'h0280_0000;
    evaluate();
    chk("inst_only_dok", 32'(inst_data_ok), 1);
    chk("inst_only_rdata", inst_rdata, 32'h0280_0000);
    chk("inst_only_data_dok", 32'(data_data_ok), 0);
    advance();
    mem_data_ok = 0;

    // conflict in one cycle, then each served
    inst_req = 1; inst_addr = 32'h100; data_req = 1; data_addr = 32'h200; mem_addr_ok = 1;
    step();
    step();
    drain();

    // lock: inst waits three cycles while data rises
    inst_req = 1; inst_addr = 32'h300; mem_addr_ok = 0;
    step();
    data_req = 1; data_addr = 32'h400; data_wr = 1; data_wdata = 32'h1234; data_wstrb = 4'hF;
    step();
    evaluate();
    chk("lock_addr", mem_addr, 32'h300);
    advance();
    mem_addr_ok = 1;
    step();
    inst_req = 0;
    step();
    data_req = 0;
    drain();

    // order tracking: inst then data, responses routed in order
    inst_req = 1; inst_addr = 32'h100; mem_addr_ok = 1;
    step();
    inst_req = 0; data_req = 1; data_wr = 0; data_addr = 32'h200;
    step();
    data_req = 0; mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'hAAAA;
    evaluate();
    chk("order_first", 32'({inst_data_ok, data_data_ok}), 32'b10);
    advance();
    mem_rdata = 32'hBBBB;
    evaluate();
    chk("order_second", 32'({inst_data_ok, data_data_ok}), 32'b01);
    advance();
    mem_data_ok = 0;

    // full: two accepts then blocked, even with a same-cycle pop
    inst_req = 1; inst_addr = 32'h500; data_req = 1; data_addr = 32'h600; mem_addr_ok = 1;
    step();
    step();
    inst_addr = 32'h700; data_addr = 32'h800;
    evaluate();
    chk("full_block", 32'(mem_req), 0);
    advance();
    mem_data_ok = 1; mem_rdata = 32'h55;
    evaluate();
    chk("full_pop_block", 32'(mem_req), 0);
    advance();
    mem_data_ok = 0;
    evaluate();
    chk("full_regrant", 32'(mem_req), 1);
    advance();
    step();
    drain();

    // reset while a data request is locked and one inst is outstanding
    inst_req = 1; inst_addr = 32'h900; mem_addr_ok = 1;
    step();
    inst_req = 0; data_req = 1; data_addr = 32'hA00; mem_addr_ok = 0;
    step();
    #1;
    mem_addr_ok = 1; mem_data_ok = 1;
    resetn = 0;
    #1;
    check_outputs_zero("async_rst");
    model_reset();
    @(posedge clk); #1;
    resetn = 1;
    data_req = 0; mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'h77;
    evaluate();
    chk("stray_dok", 32'({inst_data_ok, data_data_ok}), 0);
    advance();
    mem_data_ok = 0;

    // random traffic
    for (int i = 0; i < 2000; i++) begin
      gen_random();
      step();
    end
    mem_addr_ok = 1;
    for (int i = 0; i < 4; i++) begin
      mem_data_ok = 0;
      step();
      if (!inst_hold) inst_req = 0;
      if (!data_hold) data_req = 0;
    end
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
